// File: rtl/trng_conditioner_if.sv
// Handshake bundle between the entropy conditioner and its producer/consumer.
// Carries enable, raw samples, mode, pop/clear requests and word/status outputs.
interface trng_conditioner_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8
);
  logic             ena;
  logic [NCH-1:0]   raw_in;
  logic             sample_stb;
  logic             mode;
  logic             rd_req;
  logic             clr_fail;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             health_fail;
  logic             overrun;

  modport master (
    output ena, raw_in, sample_stb, mode,
    output rd_req, clr_fail,
    input  data_out, data_valid,
    input  health_fail, overrun
  );

  modport slave (
    input  ena, raw_in, sample_stb, mode,
    input  rd_req, clr_fail,
    output data_out, data_valid,
    output health_fail, overrun
  );
endinterface

// File: rtl/trng_conditioner.sv
// TRNG conditioner: XOR-folds NCH raw channels, optional von Neumann debias,
// repetition health test, and packs bits into WIDTH-bit words.
// Ports: clk, rst_n (async active-low), bus (slave side of the bundle).
module trng_conditioner #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 8,
  parameter int REP_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  trng_conditioner_if.slave bus
);

  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int REPW = $clog2(REP_LIMIT + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);
  localparam logic [REPW-1:0] LIM  = REPW'(REP_LIMIT);

  typedef enum logic {
    IDLE,
    HAVE_FIRST
  } pend_e;

  pend_e            state_q;
  logic             pbit_q;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             dv_q, dv_d;
  logic             hf_q, hf_d;
  logic             ov_q, ov_d;
  logic [REPW-1:0]  rep_q, rep_d;
  logic             prev_q, prev_d;

  logic             fold_b;
  logic             strobe;
  logic             rep_same;
  logic [REPW-1:0]  rep_nxt;
  logic             trip;
  logic             use_b;
  logic             kill;
  logic             new_v;
  logic             new_b;
  logic [WIDTH-1:0] word;
  logic             last;

  assign fold_b   = ^bus.raw_in;
  assign strobe   = bus.ena & bus.sample_stb & ~hf_q;
  assign rep_same = (rep_q != '0) & (fold_b == prev_q);

  always_comb begin
    rep_nxt = REPW'(1);
    if (rep_same) begin
      rep_nxt = (rep_q >= LIM) ? LIM : rep_q + REPW'(1);
    end
  end

  // The sample that trips the alarm is not fed to the assembler.
  assign trip  = strobe & (rep_nxt >= LIM);
  assign use_b = strobe & ~trip;
  assign kill  = hf_q | trip;

  // Debias emits the stored first bit of an unequal pair.
  always_comb begin
    new_v = 1'b0;
    new_b = fold_b;
    if (!bus.mode) begin
      new_v = use_b;
    end else begin
      new_v = use_b & (state_q == HAVE_FIRST) & (fold_b != pbit_q);
      new_b = pbit_q;
    end
  end

  assign word = {sr_q[WIDTH-2:0], new_b};
  assign last = new_v & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pbit_q  <= 1'b0;
    end else if (bus.ena) begin
      if (!bus.mode || kill) begin
        state_q <= IDLE;
      end else if (use_b) begin
        unique case (state_q)
          IDLE: begin
            state_q <= HAVE_FIRST;
            pbit_q  <= fold_b;
          end
          HAVE_FIRST: state_q <= IDLE;
          default:    state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    do_d   = do_q;
    dv_d   = dv_q;
    hf_d   = hf_q;
    ov_d   = ov_q;
    rep_d  = rep_q;
    prev_d = prev_q;
    if (new_v) begin
      sr_d  = word;
      cnt_d = last ? '0 : cnt_q + CNTW'(1);
    end
    if (last) begin
      if (!dv_q || bus.rd_req) begin
        do_d = word;
        dv_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (bus.rd_req && dv_q) begin
      dv_d = 1'b0;
    end
    if (strobe) begin
      rep_d  = rep_nxt;
      prev_d = fold_b;
    end
    if (trip) begin
      hf_d = 1'b1;
    end
    if (kill) begin
      dv_d  = 1'b0;
      cnt_d = '0;
    end
    if (bus.clr_fail) begin
      hf_d  = 1'b0;
      rep_d = '0;
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      do_q   <= '0;
      dv_q   <= 1'b0;
      hf_q   <= 1'b0;
      ov_q   <= 1'b0;
      rep_q  <= '0;
      prev_q <= 1'b0;
    end else if (bus.ena) begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      do_q   <= do_d;
      dv_q   <= dv_d;
      hf_q   <= hf_d;
      ov_q   <= ov_d;
      rep_q  <= rep_d;
      prev_q <= prev_d;
    end
  end

  assign bus.data_out    = do_q;
  assign bus.data_valid  = dv_q;
  assign bus.health_fail = hf_q;
  assign bus.overrun     = ov_q;

endmodule

// File: doc/trng_conditioner.md
TRNG_CONDITIONER -- requirements
Module: trng_conditioner

Interface
REQ-001 Parameter NCH, default 4, number of entropy channels folded per sample (>=1).
REQ-002 Parameter WIDTH, default 8, output word width in bits (>=2).
REQ-003 Parameter REP_LIMIT, default 16, repetition-count cutoff (>=2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  block enable; low freezes all state, all other inputs ignored.
REQ-007 raw_in  input  NCH  synchronised raw entropy bits.
REQ-008 sample_stb  input  1  one-cycle strobe: sample raw_in this cycle.
REQ-009 mode  input  1  0 = XOR-fold direct, 1 = XOR-fold plus von Neumann debias.
REQ-010 rd_req  input  1  consumer pops current word.
REQ-011 clr_fail  input  1  clears health alarm and repetition counter.
REQ-012 data_out  output  WIDTH  assembled random word.
REQ-013 data_valid  output  1  data_out holds an unread word.
REQ-014 health_fail  output  1  sticky repetition-test alarm.
REQ-015 overrun  output  1  sticky: a completed word was dropped.

Function
REQ-016 Accepted sample: ena=1 and sample_stb=1 and health_fail=0; folded bit b = XOR of all raw_in bits.
REQ-017 Mode 0: every accepted b is shifted into the assembly register.
REQ-018 Mode 1: pending-flag FSM, states IDLE/HAVE_FIRST; IDLE stores b, goes HAVE_FIRST; HAVE_FIRST emits stored bit if b differs, discards both if equal, returns IDLE.
REQ-019 Pending flag cleared whenever mode=0 on any clock.
REQ-020 Assembly: shift left, new bit into bit 0; bit counter 0..WIDTH-1; first-accepted bit ends as MSB.
REQ-021 On the edge accepting the WIDTH-th bit: counter wraps to 0; if data_valid=0 or rd_req=1, word registered to data_out and data_valid=1 (visible next cycle).
REQ-022 Completion with data_valid=1 and rd_req=0: new word dropped, data_out unchanged, overrun set.
REQ-023 rd_req with data_valid=1 and no same-cycle completion: data_valid cleared next cycle; data_out holds last value.
REQ-024 rd_req with data_valid=0: ignored.
REQ-025 Repetition test on folded b (pre-debias), every strobe with ena=1 and health_fail=0: first sample sets count=1; equal to previous increments; different resets to 1; count saturates.
REQ-026 Count reaching REP_LIMIT sets health_fail on that edge; that sample is not used.
REQ-027 While health_fail=1: no bits accepted, data_valid forced 0, bit counter and pending flag held at 0.
REQ-028 clr_fail=1: health_fail=0, count=0, overrun=0; clr_fail wins over a same-cycle set.
REQ-029 ena=0: all registers hold, including rd_req and clr_fail effects suppressed.

Reset
REQ-030 rst_n low asynchronously clears data_out, data_valid, health_fail, overrun, bit counter, shift register, pending flag and repetition count to 0; FSM to IDLE.
REQ-031 Reset mid-word discards partial bits; first post-reset word contains only post-reset samples.

Verification (NCH=4, WIDTH=8, REP_LIMIT=16)
REQ-032 Mode 0, folded bits 1,0,1,1,0,0,1,0 -> data_out=0xB2, data_valid=1 the cycle after 8th strobe.
REQ-033 Mode 1, folded pairs (0,1)(1,1)(1,0)(0,0) repeated 4x -> emits 0,1 per repeat; data_out=0x55 after 8 emitted bits.
REQ-034 16 strobes with raw_in=4'b0001 -> health_fail=1 after 16th, data_valid=0; clr_fail pulse -> health_fail=0, fresh word assembles normally.
REQ-035 Two words completed with no rd_req -> data_out keeps first word, overrun=1; rd_req same cycle as third completion -> data_out=third word, data_valid stays 1.
REQ-036 rst_n low after 5 accepted bits, then 8 bits 0xA5 -> data_out=0xA5, all flags 0.
REQ-037 ena=0 with strobes and rd_req active -> no output or state change.
